// File: rtl/ni_pkg.sv
// Shared sizing and flit layout for the core/NoC network interface.
package ni_pkg;
  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;
  localparam int PTR_W  = 5;
  localparam int FLIT_W = 64;

  localparam int FLIT_ADDR_HI = 63;
  localparam int FLIT_ADDR_LO = 32;
  localparam int FLIT_DATA_HI = 31;
  localparam int FLIT_DATA_LO = 0;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } flit_t;
endpackage

// File: rtl/ni_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is visible combinationally.
module ni_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  logic [WIDTH-1:0] fifo_ff [0:DEPTH-1];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_head    = fifo_ff[r_rd_ptr[PTR_W-1:0]];
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) fifo_ff[r_wr_ptr[PTR_W-1:0]] <= i_din;
  end
endmodule

// File: rtl/ni.sv
// Network interface: core writes drain to the router as flits, router words queue for the core.
module ni
  import ni_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] core_write_data,
  input  logic [DATA_W-1:0] core_write_addr,
  input  logic              core_write_en,
  input  logic              core_read_en,
  output logic [DATA_W-1:0] core_read_data,
  output logic              core_write_full,
  output logic              core_read_empty,
  output logic [FLIT_W-1:0] net_tx_flit,
  output logic              net_tx_valid,
  input  logic              net_tx_ready,
  input  logic [DATA_W-1:0] net_rx_flit,
  input  logic              net_rx_valid,
  output logic              net_rx_ready
);
  flit_t             w_wr_din;
  flit_t             w_tx_head;
  logic              w_wr_empty;
  logic [DATA_W-1:0] w_rd_head;
  logic              w_rd_full;
  logic              w_rd_empty;
  logic              w_rd_pop;
  logic [DATA_W-1:0] r_core_read_data;

  assign w_wr_din.addr = core_write_addr;
  assign w_wr_din.data = core_write_data;

  ni_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) write_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (core_write_en),
    .i_din   (w_wr_din),
    .i_pop   (net_tx_ready),
    .o_head  (w_tx_head),
    .o_full  (core_write_full),
    .o_empty (w_wr_empty)
  );

  assign net_tx_flit  = w_tx_head;
  assign net_tx_valid = ~w_wr_empty;

  assign w_rd_pop = core_read_en & ~w_rd_empty;
  // Advertise space when a core pop this cycle frees a slot in a full FIFO.
  assign net_rx_ready = ~w_rd_full | w_rd_pop;

  ni_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) read_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (net_rx_valid & net_rx_ready),
    .i_din   (net_rx_flit),
    .i_pop   (w_rd_pop),
    .o_head  (w_rd_head),
    .o_full  (w_rd_full),
    .o_empty (w_rd_empty)
  );

  assign core_read_empty = w_rd_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_core_read_data <= '0;
    else if (core_read_en)
      r_core_read_data <= w_rd_empty ? '0 : w_rd_head;
  end

  assign core_read_data = r_core_read_data;
endmodule

// File: tb/tb_ni.sv
// Directed bench for ni: per-cycle vector table plus hand-written fill/drain/wrap sequences.
module tb_ni;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] core_write_data = '0, core_write_addr = '0;
  logic        core_write_en = 1'b0, core_read_en = 1'b0;
  logic [31:0] core_read_data;
  logic        core_write_full, core_read_empty;
  logic [63:0] net_tx_flit;
  logic        net_tx_valid;
  logic        net_tx_ready = 1'b0;
  logic [31:0] net_rx_flit = '0;
  logic        net_rx_valid = 1'b0;
  logic        net_rx_ready;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ni dut (
    .clk(clk), .reset(reset),
    .core_write_data(core_write_data), .core_write_addr(core_write_addr),
    .core_write_en(core_write_en), .core_read_en(core_read_en),
    .core_read_data(core_read_data), .core_write_full(core_write_full),
    .core_read_empty(core_read_empty), .net_tx_flit(net_tx_flit),
    .net_tx_valid(net_tx_valid), .net_tx_ready(net_tx_ready),
    .net_rx_flit(net_rx_flit), .net_rx_valid(net_rx_valid),
    .net_rx_ready(net_rx_ready)
  );

  typedef struct {
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd_en;
    logic        tx_rdy;
    logic        rx_vld;
    logic [31:0] rx_flit;
    logic        e_txv;
    logic [63:0] e_flit;
    logic        e_full;
    logic        e_empty;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [8];
  logic [31:0] q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    core_write_en = 0; core_read_en = 0; net_tx_ready = 0; net_rx_valid = 0;
  endtask

  initial begin
    // Each row: inputs applied for one edge, outputs expected just after it.
    vecs[0] = '{1'b1, 32'hA5A5A5A5, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0, 32'h0,
                1'b1, 64'hA5A5A5A5AAAAAAAA, 1'b0, 1'b1, 32'h0};
    vecs[1] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,
                1'b1, 64'hA5A5A5A5AAAAAAAA, 1'b0, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1,
                1'b0, 64'h0, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h2,
                1'b0, 64'h0, 1'b0, 1'b0, 32'h1};
    vecs[4] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h3,
                1'b0, 64'h0, 1'b0, 1'b0, 32'h2};
    vecs[5] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,
                1'b0, 64'h0, 1'b0, 1'b1, 32'h3};
    vecs[6] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                1'b0, 64'h0, 1'b0, 1'b1, 32'h3};
    vecs[7] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,
                1'b0, 64'h0, 1'b0, 1'b1, 32'h0};

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_data", core_read_data, 0);
    check("rst_rd_empty", core_read_empty, 1);
    check("rst_tx_valid", net_tx_valid, 0);
    check("rst_wr_full", core_write_full, 0);
    check("rst_rx_ready", net_rx_ready, 1);
    check("rst_wr_ptr", dut.write_fifo.r_wr_ptr, 0);
    check("rst_rd_ptr", dut.write_fifo.r_rd_ptr, 0);
    reset = 1;
    step();

    for (int i = 0; i < 8; i++) begin
      core_write_en = vecs[i].wr_en; core_write_addr = vecs[i].addr;
      core_write_data = vecs[i].data; core_read_en = vecs[i].rd_en;
      net_tx_ready = vecs[i].tx_rdy; net_rx_valid = vecs[i].rx_vld;
      net_rx_flit = vecs[i].rx_flit;
      step();
      check($sformatf("v%0d_tx_valid", i), net_tx_valid, vecs[i].e_txv);
      if (vecs[i].e_txv) check($sformatf("v%0d_tx_flit", i), net_tx_flit, vecs[i].e_flit);
      check($sformatf("v%0d_wr_full", i), core_write_full, vecs[i].e_full);
      check($sformatf("v%0d_rd_empty", i), core_read_empty, vecs[i].e_empty);
      check($sformatf("v%0d_rd_data", i), core_read_data, vecs[i].e_rd);
      if (i == 0) check("v0_fifo_ff0", dut.write_fifo.fifo_ff[0], 64'hA5A5A5A5AAAAAAAA);
    end
    idle();

    // Asynchronous reset mid-stream
    core_write_en = 1; core_write_addr = 32'h11; core_write_data = 32'h22;
    net_rx_valid = 1; net_rx_flit = 32'h9;
    step();
    core_write_en = 0; net_rx_flit = 32'h7; core_read_en = 1;
    step();
    idle();
    check("mid_tx_valid", net_tx_valid, 1);
    check("mid_rd_data", core_read_data, 32'h9);
    check("mid_rd_empty", core_read_empty, 0);
    #2 reset = 0;
    #1;
    check("arst_tx_valid", net_tx_valid, 0);
    check("arst_rd_data", core_read_data, 0);
    check("arst_rd_empty", core_read_empty, 1);
    check("arst_wr_ptr", dut.write_fifo.r_wr_ptr, 0);
    step();
    reset = 1;
    step();

    // Fill write FIFO with tx blocked; 33rd push is dropped
    for (int i = 0; i < 32; i++) begin
      core_write_en = 1; core_write_addr = 32'h1000 + i; core_write_data = i;
      step();
    end
    check("fill_full", core_write_full, 1);
    core_write_addr = 32'hDEAD; core_write_data = 32'hBEEF;
    step();
    core_write_en = 0;
    check("drop_full", core_write_full, 1);
    check("drop_wr_ptr", dut.write_fifo.r_wr_ptr, 6'd32);
    net_tx_ready = 1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("drain_v%0d", i), net_tx_valid, 1);
      check($sformatf("drain_f%0d", i), net_tx_flit, {32'h1000 + i, 32'(i)});
      step();
    end
    check("drain_end_valid", net_tx_valid, 0);
    check("drain_end_full", core_write_full, 0);
    idle();

    // Advance read FIFO pointers so the full-FIFO phase wraps
    for (int i = 0; i < 10; i++) begin
      net_rx_valid = 1; net_rx_flit = 32'h50 + i; q.push_back(32'h50 + i);
      step();
    end
    net_rx_valid = 0; core_read_en = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("pre_rd%0d", i), core_read_data, q.pop_front());
    end
    core_read_en = 0;
    for (int i = 0; i < 32; i++) begin
      net_rx_valid = 1; net_rx_flit = 32'h100 + i; q.push_back(32'h100 + i);
      step();
    end
    net_rx_valid = 0;
    check("rfull_rx_ready", net_rx_ready, 0);
    check("rfull_empty", core_read_empty, 0);
    // Simultaneous rx push and core pop while full
    for (int k = 0; k < 8; k++) begin
      net_rx_valid = 1; net_rx_flit = 32'h200 + k; core_read_en = 1;
      #1 check($sformatf("sim_rdy%0d", k), net_rx_ready, 1);
      step();
      check($sformatf("sim_rd%0d", k), core_read_data, q.pop_front());
      q.push_back(32'h200 + k);
    end
    idle();
    #1 check("sim_still_full", net_rx_ready, 0);
    core_read_en = 1;
    for (int i = 0; i < 32; i++) begin
      step();
      check($sformatf("wrap_rd%0d", i), core_read_data, q.pop_front());
    end
    core_read_en = 0;
    check("wrap_empty", core_read_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
